// File: rtl/mean_threshold.sv
// mean_threshold
//   Reads every pixel's B byte from RAM once the grayscale stage finishes,
//   sums them, and divides the sum by PIXEL_COUNT with an 8-step restoring
//   serial divider. The quotient is the binarization threshold.
//
//   Optional build macro: MEAN_THR_ROUND_EN
//     defined   -> threshold = round-half-up(sum / PIXEL_COUNT), saturated
//     undefined -> threshold = floor(sum / PIXEL_COUNT), saturated
//   Both builds have identical latency.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   gray_done  in   rising edge starts a run (ignored while busy)
//   RAM_out    in   RAM read data, valid one cycle after RAM_ren
//   RAM_ren    out  RAM read enable (READ state only)
//   RAM_addr   out  RAM read address (0 when RAM_ren=0)
//   threshold  out  mean gray level
//   thr_valid  out  threshold valid; held until reset or next run start
//   busy       out  run in progress
//
// Timing: from the edge that samples gray_done high (cycle 0), READ spans
// cycles 0..N-1, DRAIN cycle N, DIV cycles N+1..N+9 (one dividend-load
// cycle plus BYTE_WIDTH quotient-bit cycles); thr_valid rises at cycle N+10.
module mean_threshold #(
    parameter int BYTE_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int PIX_BASE    = 54,
    parameter int PIXEL_COUNT = 65536,
    parameter int ACC_WIDTH   = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gray_done,
    input  logic [BYTE_WIDTH-1:0] RAM_out,
    output logic                  RAM_ren,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [BYTE_WIDTH-1:0] threshold,
    output logic                  thr_valid,
    output logic                  busy
);

    localparam int CNT_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
    localparam int DVW   = ACC_WIDTH + 1;          // dividend incl. rounding add
    localparam int SW    = DVW + BYTE_WIDTH;       // room for divisor << BYTE_WIDTH
    localparam int DC_W  = $clog2(BYTE_WIDTH + 1);

`ifdef MEAN_THR_ROUND_EN
    localparam logic [DVW-1:0] ROUND_ADD = DVW'(PIXEL_COUNT / 2);
`else
    localparam logic [DVW-1:0] ROUND_ADD = '0;
`endif

    localparam logic [SW-1:0]    DIVISOR  = SW'(PIXEL_COUNT);
    localparam logic [SW-1:0]    SAT_LIM  = DIVISOR << BYTE_WIDTH;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        DIV   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  gd_q, gd_d;
    logic                  ren_q, ren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DVW-1:0]        rem_q, rem_d;
    logic [BYTE_WIDTH-1:0] quot_q, quot_d;
    logic                  sat_q, sat_d;
    logic [DC_W-1:0]       dcnt_q, dcnt_d;
    logic [BYTE_WIDTH-1:0] thr_q, thr_d;
    logic                  thr_valid_q, thr_valid_d;
    logic                  busy_q, busy_d;

    logic                  start;
    logic [DC_W-1:0]       shamt;
    logic [SW-1:0]         div_sh;
    logic [SW-1:0]         rem_ext;
    logic                  q_bit;
    logic [DVW-1:0]        dividend;

    always_comb begin
        state_d     = state_q;
        gd_d        = gray_done;
        ren_d       = ren_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rd_vld_d    = ren_q;     // data returns the cycle after a read
        acc_d       = acc_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        sat_d       = sat_q;
        dcnt_d      = dcnt_q;
        thr_d       = thr_q;
        thr_valid_d = thr_valid_q;
        busy_d      = busy_q;

        start    = gray_done & ~gd_q;
        shamt    = DC_W'(BYTE_WIDTH) - dcnt_q;
        div_sh   = DIVISOR << shamt;
        rem_ext  = SW'(rem_q);
        q_bit    = (rem_ext >= div_sh);
        dividend = DVW'(acc_q) + ROUND_ADD;

        if (rd_vld_q)
            acc_d = acc_q + ACC_WIDTH'(RAM_out);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = READ;
                    acc_d       = '0;
                    thr_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    ren_d       = 1'b1;
                    addr_d      = ADDR_WIDTH'(PIX_BASE);
                    cnt_d       = '0;
                end
            end
            READ: begin
                if (cnt_q == LAST_PIX) begin
                    state_d = DRAIN;
                    ren_d   = 1'b0;
                    addr_d  = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(3);   // skip G and R bytes
                end
            end
            DRAIN: begin
                // final byte is accumulated on this edge
                state_d = DIV;
                dcnt_d  = '0;
            end
            DIV: begin
                if (dcnt_q == '0) begin
                    // load cycle: quotient would not fit -> saturate at the end
                    rem_d  = dividend;
                    quot_d = '0;
                    sat_d  = (SW'(dividend) >= SAT_LIM);
                    dcnt_d = DC_W'(1);
                end else begin
                    if (q_bit)
                        rem_d = DVW'(rem_ext - div_sh);
                    quot_d = (quot_q << 1) | BYTE_WIDTH'(q_bit);
                    if (dcnt_q == DC_W'(BYTE_WIDTH)) begin
                        state_d     = DONE;
                        thr_d       = sat_q ? '1 : quot_d;
                        thr_valid_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gd_q        <= 1'b0;
            ren_q       <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rd_vld_q    <= 1'b0;
            acc_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            sat_q       <= 1'b0;
            dcnt_q      <= '0;
            thr_q       <= '0;
            thr_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gd_q        <= gd_d;
            ren_q       <= ren_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rd_vld_q    <= rd_vld_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            sat_q       <= sat_d;
            dcnt_q      <= dcnt_d;
            thr_q       <= thr_d;
            thr_valid_q <= thr_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign RAM_ren   = ren_q;
    assign RAM_addr  = addr_q;
    assign threshold = thr_q;
    assign thr_valid = thr_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mean_threshold.sv
module tb_mean_threshold;

  localparam int N    = 16;
  localparam int BASE = 54;

  logic        gclk = 1'b0;
  logic        rst;
  logic        gray_done;
  logic [7:0]  ram_out, ram_out_a;
  logic        ram_ren, ram_ren_a;
  logic [19:0] ram_addr, ram_addr_a;
  logic [7:0]  thr, thr_a;
  logic        thr_vld, thr_vld_a;
  logic        busy, busy_a;

  logic [7:0]  mem  [0:127];
  logic [7:0]  mem_a[0:127];

  int n_vec = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  mean_threshold #(.PIXEL_COUNT(N)) u_dut (
    .clk(gclk), .rst(rst), .gray_done(gray_done), .RAM_out(ram_out),
    .RAM_ren(ram_ren), .RAM_addr(ram_addr), .threshold(thr),
    .thr_valid(thr_vld), .busy(busy)
  );

  mean_threshold #(.PIXEL_COUNT(1)) u_dut_a (
    .clk(gclk), .rst(rst), .gray_done(gray_done), .RAM_out(ram_out_a),
    .RAM_ren(ram_ren_a), .RAM_addr(ram_addr_a), .threshold(thr_a),
    .thr_valid(thr_vld_a), .busy(busy_a)
  );

  // synchronous RAMs: data valid the cycle after the read enable
  always @(posedge gclk) begin
    ram_out   <= ram_ren   ? mem[ram_addr[6:0]]     : 8'h00;
    ram_out_a <= ram_ren_a ? mem_a[ram_addr_a[6:0]] : 8'h00;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk); #1;
  endtask

  function automatic int mean_of(input int cnt, input int s);
    int q;
`ifdef MEAN_THR_ROUND_EN
    q = (s + cnt / 2) / cnt;
`else
    q = s / cnt;
`endif
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int model_main();
    int s = 0;
    for (int j = 0; j < N; j++) s += mem[BASE + 3*j];
    return mean_of(N, s);
  endfunction

  // mode: 0 const val, 1 alternate 0/val, 2 random
  task automatic fill(input int mode, input int val);
    for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    for (int j = 0; j < N; j++)
      case (mode)
        0: mem[BASE + 3*j] = 8'(val);
        1: mem[BASE + 3*j] = (j % 2 == 1) ? 8'(val) : 8'd0;
        default: mem[BASE + 3*j] = 8'($urandom);
      endcase
    mem_a[BASE] = 8'($urandom);
  endtask

  task automatic start_run();
    gray_done = 1'b1;
    tick();               // now just after the sampling edge (cycle 0)
  endtask

  // Runs from cycle 0 to thr_valid, checking address stream and latency.
  task automatic finish_run(input string tag, input bit pulse, input bit poke);
    int lat = -1;
    for (int k = 0; k <= N + 30; k++) begin
      if (k < N) begin
        chk({tag, ".ren"}, int'(ram_ren), 1);
        chk({tag, ".addr"}, int'(ram_addr), BASE + 3*k);
      end else if (k == N) begin
        chk({tag, ".ren_off"}, int'(ram_ren), 0);
        chk({tag, ".addr_off"}, int'(ram_addr), 0);
      end
      if (thr_vld) begin lat = k; break; end
      if (pulse && k == 0) gray_done = 1'b0;
      if (poke) begin
        if (k == N + 3) gray_done = 1'b0;
        if (k == N + 5) gray_done = 1'b1;
        if (k == N + 7) gray_done = 1'b0;
      end
      tick();
    end
    chk({tag, ".latency"}, lat, N + 10);
    chk({tag, ".thr"}, int'(thr), model_main());
    chk({tag, ".busy"}, int'(busy), 0);
    // single-pixel instance finishes earlier; confirm its result too
    for (int k = 0; k < 20 && !thr_vld_a; k++) tick();
    chk({tag, ".one_pix"}, int'(thr_a), mean_of(1, mem_a[BASE]));
  endtask

  initial begin
    int runs;
    bit prev;
    rst = 1'b1;
    gray_done = 1'b0;
    tick(); tick();
    chk("rst.ren", int'(ram_ren), 0);
    chk("rst.addr", int'(ram_addr), 0);
    chk("rst.thr", int'(thr), 0);
    chk("rst.vld", int'(thr_vld), 0);
    chk("rst.busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    fill(0, 100); start_run(); finish_run("all100", 1, 0);
    chk("all100.val", int'(thr), 100);
    fill(1, 255); start_run(); finish_run("alt0_255", 1, 0);
    fill(0, 255); start_run(); finish_run("all255", 1, 0);
    chk("all255.val", int'(thr), 255);
    fill(0, 0); start_run(); finish_run("all0", 1, 0);
    for (int r = 0; r < 4; r++) begin
      fill(2, 0); start_run(); finish_run("rand", 1, 0);
    end
    fill(2, 0); start_run(); finish_run("div_edge", 1, 1);

    // reset at READ pixel 5
    fill(2, 0); start_run(); gray_done = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("abort.addr5", int'(ram_addr), BASE + 15);
    rst = 1'b1; tick();
    chk("abort.ren", int'(ram_ren), 0);
    chk("abort.addr", int'(ram_addr), 0);
    chk("abort.thr", int'(thr), 0);
    chk("abort.vld", int'(thr_vld), 0);
    chk("abort.busy", int'(busy), 0);
    rst = 1'b0;
    runs = 0;
    for (int k = 0; k < 30; k++) begin tick(); if (thr_vld) runs++; end
    chk("abort.no_vld", runs, 0);
    fill(2, 0); start_run(); finish_run("after_abort", 1, 0);

    // gray_done held high: one run only
    fill(2, 0); gray_done = 1'b1; runs = 0; prev = thr_vld;
    for (int k = 0; k < 3 * (N + 10); k++) begin
      tick();
      if (thr_vld && !prev) runs++;
      prev = thr_vld;
    end
    chk("held.runs", runs, 1);
    chk("held.thr", int'(thr), model_main());
    gray_done = 1'b0; tick();
    fill(2, 0); start_run();
    chk("restart.vld_drop", int'(thr_vld), 0);
    finish_run("restart", 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
